// File: rtl/cw_capture_pkg.sv
// Shared definitions for the capture controller: FSM state encoding and names.
package cw_capture_pkg;

    localparam int CW_STATE_W = 3;

    typedef enum logic [CW_STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_PRE_FILL  = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POST      = 3'd3,
        ST_DONE      = 3'd4
    } cw_state_t;

endpackage

// File: rtl/cw_trig_match.sv
// Combinational trigger comparator: a sample matches when every masked bit
// equals the corresponding bit of the compare pattern.
module cw_trig_match #(
    parameter int DATA_W = 10
) (
    input  logic [DATA_W-1:0] sample,
    input  logic [DATA_W-1:0] mask,
    input  logic [DATA_W-1:0] value,
    output logic              match
);

    // Unmasked bits never block a match, so an all-zero mask always matches.
    always_comb begin
        match = (((sample ^ value) & mask) == '0);
    end

endmodule

// File: rtl/cw_capture_ctrl.sv
// Capture controller for a circular sample memory: optional pre-trigger fill,
// trigger search over a masked pattern, then a fixed number of post-trigger
// samples. Every sampled bus value is presented to the memory one cycle later.
module cw_capture_ctrl
    import cw_capture_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 1024
) (
    input  logic              trig_clk,
    input  logic              trig_rst,
    input  logic              arm,
    input  logic              abort,
    input  logic [DATA_W-1:0] bus_din,
    input  logic [DATA_W-1:0] trig_mask,
    input  logic [DATA_W-1:0] trig_value,
    input  logic [ADDR_W-1:0] pre_len,
    input  logic [ADDR_W-1:0] post_len,
    output logic              wt_ce,
    output logic              wt_en,
    output logic [ADDR_W-1:0] wt_addr,
    output logic [DATA_W-1:0] wt_data,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic [ADDR_W-1:0] trig_addr,
    output logic [ADDR_W-1:0] start_addr
);

    // DEPTH may equal 2^ADDR_W; truncating it makes modular address math work
    // in ADDR_W bits either way.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] DEPTH_MOD = ADDR_W'(DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    cw_state_t         state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] pre_l;
    logic [ADDR_W-1:0] post_l;
    logic [DATA_W-1:0] mask_l;
    logic [DATA_W-1:0] value_l;
    logic              fin;

    logic              match;
    logic              capture;
    logic              cfg_bad;
    logic [ADDR_W:0]   cfg_sum;
    logic [ADDR_W-1:0] ptr_next;
    logic [ADDR_W-1:0] start_calc;

    cw_trig_match #(
        .DATA_W (DATA_W)
    ) u_match (
        .sample (bus_din),
        .mask   (mask_l),
        .value  (value_l),
        .match  (match)
    );

    // Configuration check, pointer wrap and oldest-sample address arithmetic.
    // The fin flag marks the extra POST cycle in which the final write is on
    // the memory port, so the first DONE cycle has no write in flight.
    always_comb begin
        cfg_sum    = {1'b0, pre_len} + {1'b0, post_len};
        cfg_bad    = (cfg_sum >= DEPTH_EXT);
        ptr_next   = (ptr == LAST_ADDR) ? '0 : ptr + 1'b1;
        start_calc = (ptr >= pre_l) ? (ptr - pre_l) : (ptr - pre_l + DEPTH_MOD);
        capture    = ((state == ST_PRE_FILL) || (state == ST_WAIT_TRIG) ||
                      (state == ST_POST)) && !fin;
    end

    // Capture FSM with registered memory-port and status outputs; reset beats
    // abort, and abort beats arm and trigger.
    always_ff @(posedge trig_clk) begin
        if (trig_rst) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            cnt        <= '0;
            pre_l      <= '0;
            post_l     <= '0;
            mask_l     <= '0;
            value_l    <= '0;
            fin        <= 1'b0;
            wt_ce      <= 1'b0;
            wt_en      <= 1'b0;
            wt_addr    <= '0;
            wt_data    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cfg_err    <= 1'b0;
            trig_addr  <= '0;
            start_addr <= '0;
        end else if (abort) begin
            state   <= ST_IDLE;
            fin     <= 1'b0;
            wt_ce   <= 1'b0;
            wt_en   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            wt_en   <= 1'b0;

            if (capture) begin
                wt_en   <= 1'b1;
                wt_data <= bus_din;
                wt_addr <= ptr;
                ptr     <= ptr_next;
            end

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        if (cfg_bad) begin
                            cfg_err <= 1'b1;
                        end else begin
                            pre_l   <= pre_len;
                            post_l  <= post_len;
                            mask_l  <= trig_mask;
                            value_l <= trig_value;
                            ptr     <= '0;
                            cnt     <= '0;
                            fin     <= 1'b0;
                            busy    <= 1'b1;
                            wt_ce   <= 1'b1;
                            done    <= 1'b0;
                            state   <= (pre_len != '0) ? ST_PRE_FILL : ST_WAIT_TRIG;
                        end
                    end
                end
                ST_PRE_FILL: begin
                    if (cnt == pre_l - 1'b1) begin
                        cnt   <= '0;
                        state <= ST_WAIT_TRIG;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WAIT_TRIG: begin
                    if (match) begin
                        trig_addr  <= ptr;
                        start_addr <= start_calc;
                        cnt        <= '0;
                        fin        <= (post_l == '0);
                        state      <= ST_POST;
                    end
                end
                ST_POST: begin
                    if (fin) begin
                        fin   <= 1'b0;
                        busy  <= 1'b0;
                        wt_ce <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == post_l - 1'b1) begin
                            fin <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cw_capture_ctrl.sv
// Self-checking bench for cw_capture_ctrl: directed captures, with expected
// memory writes queued by the stimulus and popped by an independent monitor.
module tb_cw_capture_ctrl;

    localparam int DATA_W = 10;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 16;

    logic              trig_clk = 1'b0;
    logic              trig_rst;
    logic              arm;
    logic              abort;
    logic [DATA_W-1:0] bus_din;
    logic [DATA_W-1:0] trig_mask;
    logic [DATA_W-1:0] trig_value;
    logic [ADDR_W-1:0] pre_len;
    logic [ADDR_W-1:0] post_len;
    logic              wt_ce;
    logic              wt_en;
    logic [ADDR_W-1:0] wt_addr;
    logic [DATA_W-1:0] wt_data;
    logic              busy;
    logic              done;
    logic              cfg_err;
    logic [ADDR_W-1:0] trig_addr;
    logic [ADDR_W-1:0] start_addr;

    int errors = 0;
    int checks = 0;
    logic [ADDR_W+DATA_W-1:0] sb[$];

    cw_capture_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .trig_clk   (trig_clk),
        .trig_rst   (trig_rst),
        .arm        (arm),
        .abort      (abort),
        .bus_din    (bus_din),
        .trig_mask  (trig_mask),
        .trig_value (trig_value),
        .pre_len    (pre_len),
        .post_len   (post_len),
        .wt_ce      (wt_ce),
        .wt_en      (wt_en),
        .wt_addr    (wt_addr),
        .wt_data    (wt_data),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err),
        .trig_addr  (trig_addr),
        .start_addr (start_addr)
    );

    always #5 trig_clk = ~trig_clk;

    // Compare one value against its expectation and record the outcome.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of control/data, wait for the edge, release pulses.
    task automatic applyStimulus(input logic a, input logic ab, input logic [DATA_W-1:0] d);
        arm     = a;
        abort   = ab;
        bus_din = d;
        @(posedge trig_clk);
        #1;
        arm   = 1'b0;
        abort = 1'b0;
    endtask

    function automatic logic [DATA_W-1:0] sample_val(input int k);
        return DATA_W'((k * 37 + 3) % 1024);
    endfunction

    // Monitor: every presented memory write must match the oldest queued one.
    always @(negedge trig_clk) begin
        if (wt_en === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                         wt_addr, wt_data);
            end else begin
                logic [ADDR_W+DATA_W-1:0] exp;
                exp = sb.pop_front();
                checkOutput("wt_addr", 32'(wt_addr), 32'(exp[ADDR_W+DATA_W-1:DATA_W]));
                checkOutput("wt_data", 32'(wt_data), 32'(exp[DATA_W-1:0]));
                checkOutput("wt_ce_with_en", 32'(wt_ce), 32'd1);
            end
        end
    end

    // One complete capture; configuration inputs are scrambled after arm so
    // a controller that does not latch them mis-triggers.
    task automatic runCapture(input string name, input int pre, input int post,
                              input logic [DATA_W-1:0] mask, input logic [DATA_W-1:0] value,
                              input int trig_idx, input bit early,
                              input int exp_trig, input int exp_start);
        logic [DATA_W-1:0] d;
        trig_mask  = mask;
        trig_value = value;
        pre_len    = ADDR_W'(pre);
        post_len   = ADDR_W'(post);
        applyStimulus(1'b1, 1'b0, '0);
        trig_mask  = '0;
        trig_value = '0;
        pre_len    = '0;
        post_len   = '0;
        checkOutput({name, "_busy_after_arm"}, 32'(busy), 32'd1);
        for (int k = 0; k < trig_idx + post + 1; k++) begin
            if (k == trig_idx)
                d = value;
            else if (early && k == 2)
                d = 10'h155;
            else
                d = sample_val(k);
            sb.push_back({ADDR_W'(k % DEPTH), d});
            applyStimulus(1'b0, 1'b0, d);
        end
        checkOutput({name, "_done_last_write"}, 32'(done), 32'd0);
        checkOutput({name, "_busy_last_write"}, 32'(busy), 32'd1);
        applyStimulus(1'b0, 1'b0, sample_val(99));
        checkOutput({name, "_done"}, 32'(done), 32'd1);
        checkOutput({name, "_busy_done"}, 32'(busy), 32'd0);
        checkOutput({name, "_wt_en_done"}, 32'(wt_en), 32'd0);
        checkOutput({name, "_trig_addr"}, 32'(trig_addr), 32'(exp_trig));
        checkOutput({name, "_start_addr"}, 32'(start_addr), 32'(exp_start));
        checkOutput({name, "_writes_drained"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        trig_rst   = 1'b1;
        arm        = 1'b0;
        abort      = 1'b0;
        bus_din    = '0;
        trig_mask  = '0;
        trig_value = '0;
        pre_len    = '0;
        post_len   = '0;
        applyStimulus(1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_wt_en", 32'(wt_en), 32'd0);
        checkOutput("rst_trig_addr", 32'(trig_addr), 32'd0);
        trig_rst = 1'b0;
        applyStimulus(1'b0, 1'b0, '0);

        $display("[TB] mask zero: first eligible sample after pre-fill triggers");
        runCapture("mask0", 3, 1, 10'h000, 10'h2AA, 3, 1'b0, 3, 0);

        $display("[TB] basic capture, trigger at sample 10");
        runCapture("basic", 4, 3, 10'h3FF, 10'h155, 10, 1'b0, 10, 6);

        $display("[TB] match during pre-fill is ignored");
        runCapture("early", 4, 3, 10'h3FF, 10'h155, 10, 1'b1, 10, 6);

        $display("[TB] wrapping capture, trigger at sample 12");
        runCapture("wrap", 4, 8, 10'h3FF, 10'h155, 12, 1'b0, 12, 8);

        $display("[TB] largest legal config accepted, then aborted");
        pre_len  = 16'd10;
        post_len = 16'd5;
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("edge_busy", 32'(busy), 32'd1);
        checkOutput("edge_cfg_err", 32'(cfg_err), 32'd0);
        applyStimulus(1'b0, 1'b1, sample_val(0));
        checkOutput("edge_abort_busy", 32'(busy), 32'd0);
        checkOutput("edge_abort_wt_en", 32'(wt_en), 32'd0);

        $display("[TB] illegal config rejected");
        pre_len  = 16'd10;
        post_len = 16'd6;
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("cfg_err_pulse", 32'(cfg_err), 32'd1);
        checkOutput("cfg_err_busy", 32'(busy), 32'd0);
        checkOutput("cfg_err_done", 32'(done), 32'd0);
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("cfg_err_clear", 32'(cfg_err), 32'd0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, sample_val(i));
        checkOutput("cfg_err_still_idle", 32'(busy), 32'd0);

        $display("[TB] abort coincident with trigger");
        trig_mask  = 10'h3FF;
        trig_value = 10'h155;
        pre_len    = 16'd0;
        post_len   = 16'd3;
        applyStimulus(1'b1, 1'b0, '0);
        sb.push_back({16'd0, sample_val(0)});
        applyStimulus(1'b0, 1'b0, sample_val(0));
        sb.push_back({16'd1, sample_val(1)});
        applyStimulus(1'b0, 1'b0, sample_val(1));
        applyStimulus(1'b0, 1'b1, 10'h155);
        checkOutput("abort_wt_en", 32'(wt_en), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_trig_addr", 32'(trig_addr), 32'd12);
        checkOutput("abort_start_addr", 32'(start_addr), 32'd8);
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("abort_drained", 32'(sb.size()), 32'd0);

        $display("[TB] reset during post-trigger phase");
        trig_mask  = 10'h3FF;
        trig_value = 10'h155;
        pre_len    = 16'd2;
        post_len   = 16'd5;
        applyStimulus(1'b1, 1'b0, '0);
        for (int k = 0; k < 6; k++) begin
            logic [DATA_W-1:0] d;
            d = (k == 3) ? 10'h155 : sample_val(k);
            sb.push_back({ADDR_W'(k), d});
            applyStimulus(1'b0, 1'b0, d);
        end
        checkOutput("post_busy", 32'(busy), 32'd1);
        trig_rst = 1'b1;
        applyStimulus(1'b1, 1'b1, sample_val(6));
        trig_rst = 1'b0;
        checkOutput("mid_rst_wt_ce", 32'(wt_ce), 32'd0);
        checkOutput("mid_rst_wt_en", 32'(wt_en), 32'd0);
        checkOutput("mid_rst_wt_addr", 32'(wt_addr), 32'd0);
        checkOutput("mid_rst_wt_data", 32'(wt_data), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_done", 32'(done), 32'd0);
        checkOutput("mid_rst_cfg_err", 32'(cfg_err), 32'd0);
        checkOutput("mid_rst_trig_addr", 32'(trig_addr), 32'd0);
        checkOutput("mid_rst_start_addr", 32'(start_addr), 32'd0);
        runCapture("after_rst", 4, 3, 10'h3FF, 10'h155, 10, 1'b0, 10, 6);

        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, '0);
        checkOutput("final_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
